neuraedge_pe_job_sequencer: RTL
===============================

# neuraedge_pe_job_sequencer

Job-level sequencer for one enhanced multi-lane MAC PE. Accepts a dot-product job descriptor and an operand stream over valid/ready handshakes, and drives the PE control pins through a clear/stream/flush sequence. Compensates for the PE's one-cycle registered multiplier latency and returns the accumulated result over a valid/ready handshake. Also owns PE wake-up; idle power-down is an optional compile-time feature.

## Interface
- DATA_WIDTH, 8: operand width
- ACCUM_WIDTH, 32: PE accumulator width
- MAC_LANES, 1: PE lane count
- LEN_W, 12: job length field width
- WAKE_CYCLES, 4: power-up settle cycles before first issue, ≥1
- IDLE_TIMEOUT, 64: idle cycles before power-down, ≥1
- gated_clk  in  1  clock
- reset  in  1  asynchronous, active-high
- job_valid / job_ready  in / out  1  descriptor handshake
- job_len  in  LEN_W  operand pairs in job, 0 legal
- job_precision  in  2  0=INT8, 1=INT4, 2=INT2, 3=INT1
- job_lane_mask  in  MAC_LANES  lanes to enable
- op_valid / op_ready  in / out  1  operand-pair handshake
- op_a, op_b  in  DATA_WIDTH  operands
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  ACCUM_WIDTH  accumulated sum
- pe_enable, pe_power_gate_enable, pe_clock_gate_enable  out  1  PE power controls
- pe_data_valid, pe_accum_clear, pe_accum_enable  out  1  PE beat controls
- pe_data_a, pe_data_b  out  DATA_WIDTH  PE operands
- pe_precision_mode  out  2; pe_lane_mask  out  MAC_LANES  latched from job
- pe_accum_out  in  ACCUM_WIDTH  PE accumulator
- busy  out  1  state ∉ {OFF, IDLE}

## Operation
- States: OFF, WAKE, IDLE, CLEAR, STREAM, FLUSH, CAPTURE, RESULT.
- Reset: state OFF. All outputs 0, including res_data, job_ready, op_ready, res_valid and all pe_*.
- OFF: power pins 0. Goes to WAKE when job_valid=1; the job is not accepted in OFF.
- Power pins (pe_enable, pe_power_gate_enable, pe_clock_gate_enable) are 1 in every state except OFF.
- WAKE: counter loads WAKE_CYCLES and decrements. Goes to IDLE at 0.
- IDLE: job_ready=1. On handshake, latch len, precision and lane mask, then go to CLEAR.
- CLEAR (1 cycle): pe_data_valid=1, pe_accum_clear=1, operands 0. This zeroes the multiplier register and the accumulator.
- STREAM:
  - op_ready=1 and pe_accum_enable=1.
  - pe_data_valid = op_valid; pe_data_a/b = op_a/b.
  - Remaining count decrements per op handshake; go to FLUSH after the len-th pair.
  - When len=0, skip STREAM and go CLEAR→FLUSH.
- FLUSH (1 cycle): pe_data_valid=1, pe_accum_enable=1, operands 0. This accumulates the last pending product.
- CAPTURE (1 cycle): res_data ← pe_accum_out.
- RESULT: res_valid=1 and res_data stable until res_ready, then go to IDLE.
- Arithmetic: the PE's per-product 16-bit truncation and modulo-2^ACCUM_WIDTH wrap pass through unmodified. The sequencer does no arithmetic besides counters.
- In every state other than CLEAR/STREAM/FLUSH: pe_data_valid=0, pe_accum_* = 0, operands 0.
- Reset mid-job: asynchronous return to OFF. The job and any pending result are discarded.

## Timing
- Accept edge = cycle 0. CLEAR = cycle 1. Unstalled STREAM = cycles 2..len+1. FLUSH = len+2. CAPTURE = len+3. res_valid rises at cycle len+4.
- Each cycle with op_valid=0 in STREAM adds one cycle of latency. The PE holds state because pe_data_valid=0.
- Job throughput: one job per len+5 cycles minimum. IDLE is revisited for at least one cycle between jobs.
- job_ready, op_ready and res_valid are registered state decodes. There is no combinational path from any handshake input to any handshake output.
- job_valid asserted in the same cycle as a completed res handshake is accepted on the following IDLE cycle.

## Configuration
- NEURAEDGE_SEQ_IDLE_PWRDN_EN defined:
  - An idle counter runs in IDLE and resets whenever job_valid=1.
  - When it reaches IDLE_TIMEOUT, go to OFF (power pins drop next cycle).
  - A later job re-enters through WAKE.
- Undefined: once WAKE completes, the block never returns to OFF except on reset.

## Structure
- Shared package neuraedge_pe_pkg holds the state encodings (localparams) and precision codes.
- One sub-module, neuraedge_seq_timer: loadable down-counter with zero flag, used for WAKE and for idle timeout.

## Test plan
- Reset, INT8 job len=3, pairs (2,3), (−1,4), (5,5) → res_data=27, res_valid at cycle 7, pe_precision_mode=0.
- Same job with op_valid low 2 cycles after the first pair → res_data=27, res_valid at cycle 9, no extra pe_data_valid pulses.
- len=0 → CLEAR, FLUSH, res_data=0 at cycle 4. INT4 len=1 (4'hF, 4'h2) → res_data=0xFFFFFFFE.
- res_ready held low 5 cycles → res_valid and res_data stable, job_ready=0 throughout, IDLE one cycle after the handshake.
- Assert reset in the second STREAM beat → all outputs 0 immediately. A new job after the WAKE_CYCLES=4 wake gives the correct sum.
- With the macro: 64 idle cycles → state OFF and pe_power_gate_enable=0. A new job goes through WAKE (4 cycles) before job_ready. Without the macro, power stays 1 indefinitely.

Source files
------------

// File: rtl/neuraedge_pe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neuraedge_pe_pkg: state encodings and precision codes for the PE sequencer|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package neuraedge_pe_pkg;

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_WAKE    = 3'd1;
  localparam logic [2:0] ST_IDLE    = 3'd2;
  localparam logic [2:0] ST_CLEAR   = 3'd3;
  localparam logic [2:0] ST_STREAM  = 3'd4;
  localparam logic [2:0] ST_FLUSH   = 3'd5;
  localparam logic [2:0] ST_CAPTURE = 3'd6;
  localparam logic [2:0] ST_RESULT  = 3'd7;

  typedef enum logic [2:0] {
    S_OFF     = ST_OFF,
    S_WAKE    = ST_WAKE,
    S_IDLE    = ST_IDLE,
    S_CLEAR   = ST_CLEAR,
    S_STREAM  = ST_STREAM,
    S_FLUSH   = ST_FLUSH,
    S_CAPTURE = ST_CAPTURE,
    S_RESULT  = ST_RESULT
  } seq_state_t;

  typedef enum logic [1:0] {
    PREC_INT8 = 2'd0,
    PREC_INT4 = 2'd1,
    PREC_INT2 = 2'd2,
    PREC_INT1 = 2'd3
  } precision_t;

  function automatic logic is_busy(input seq_state_t s);
    return !(s == S_OFF || s == S_IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuraedge_seq_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neuraedge_seq_timer: loadable down-counter with zero/last flags          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
import neuraedge_pe_pkg::*;

module neuraedge_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             gated_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);
  // High on the cycle whose decrement lands on zero.
  assign last = (count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/neuraedge_pe_job_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neuraedge_pe_job_sequencer: clear/stream/flush job control for one MAC PE|
// | Optional idle power-down: NEURAEDGE_SEQ_IDLE_PWRDN_EN. Rev 1.0           |
// +--------------------------------------------------------------------------+
import neuraedge_pe_pkg::*;

module neuraedge_pe_job_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int MAC_LANES    = 1,
  parameter int LEN_W        = 12,
  parameter int WAKE_CYCLES  = 4,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                   gated_clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [LEN_W-1:0]       job_len,
  input  logic [1:0]             job_precision,
  input  logic [MAC_LANES-1:0]   job_lane_mask,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [DATA_WIDTH-1:0]  op_a,
  input  logic [DATA_WIDTH-1:0]  op_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACCUM_WIDTH-1:0] res_data,
  output logic                   pe_enable,
  output logic                   pe_power_gate_enable,
  output logic                   pe_clock_gate_enable,
  output logic                   pe_data_valid,
  output logic                   pe_accum_clear,
  output logic                   pe_accum_enable,
  output logic [DATA_WIDTH-1:0]  pe_data_a,
  output logic [DATA_WIDTH-1:0]  pe_data_b,
  output logic [1:0]             pe_precision_mode,
  output logic [MAC_LANES-1:0]   pe_lane_mask,
  input  logic [ACCUM_WIDTH-1:0] pe_accum_out,
  output logic                   busy
);

  localparam int TIMER_MAX = (WAKE_CYCLES > IDLE_TIMEOUT) ? WAKE_CYCLES : IDLE_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  seq_state_t         state;
  seq_state_t         state_nxt;
  logic [LEN_W-1:0]   remaining;
  logic               stream_q;
  logic               pad_q;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_dec;
  logic               timer_zero;
  logic               timer_last;

  wire job_fire = job_valid && job_ready;
  wire op_fire  = op_valid && op_ready;
  wire res_fire = res_valid && res_ready;

  neuraedge_seq_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .gated_clk  (gated_clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .zero       (timer_zero),
    .last       (timer_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:     if (job_valid) state_nxt = S_WAKE;
      S_WAKE:    if (timer_last || timer_zero) state_nxt = S_IDLE;
      S_IDLE: begin
        if (job_fire) state_nxt = S_CLEAR;
`ifdef NEURAEDGE_SEQ_IDLE_PWRDN_EN
        else if (timer_last || timer_zero) state_nxt = S_OFF;
`endif
      end
      S_CLEAR:   state_nxt = (remaining == '0) ? S_FLUSH : S_STREAM;
      S_STREAM:  if (op_fire && remaining == LEN_W'(1)) state_nxt = S_FLUSH;
      S_FLUSH:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_RESULT;
      S_RESULT:  if (res_fire) state_nxt = S_IDLE;
      default:   state_nxt = S_OFF;
    endcase
  end

  // One timer serves both the wake settle time and the idle timeout.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    timer_dec   = 1'b0;
    if (state == S_OFF && state_nxt == S_WAKE) begin
      timer_load  = 1'b1;
      timer_value = TIMER_W'(WAKE_CYCLES);
    end
    if (state == S_WAKE) timer_dec = 1'b1;
`ifdef NEURAEDGE_SEQ_IDLE_PWRDN_EN
    if (state_nxt == S_IDLE && state != S_IDLE) begin
      timer_load  = 1'b1;
      timer_value = TIMER_W'(IDLE_TIMEOUT);
    end
    if (state == S_IDLE) timer_dec = 1'b1;
`endif
  end

  // Control outputs are decoded from the next state so they line up with it.
  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      state                <= S_OFF;
      remaining            <= '0;
      job_ready            <= 1'b0;
      op_ready             <= 1'b0;
      res_valid            <= 1'b0;
      res_data             <= '0;
      pe_enable            <= 1'b0;
      pe_power_gate_enable <= 1'b0;
      pe_clock_gate_enable <= 1'b0;
      pe_accum_clear       <= 1'b0;
      pe_accum_enable      <= 1'b0;
      pe_precision_mode    <= 2'(PREC_INT8);
      pe_lane_mask         <= '0;
      stream_q             <= 1'b0;
      pad_q                <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_nxt;
      job_ready            <= (state_nxt == S_IDLE);
      op_ready             <= (state_nxt == S_STREAM);
      res_valid            <= (state_nxt == S_RESULT);
      pe_enable            <= (state_nxt != S_OFF);
      pe_power_gate_enable <= (state_nxt != S_OFF);
      pe_clock_gate_enable <= (state_nxt != S_OFF);
      pe_accum_clear       <= (state_nxt == S_CLEAR);
      pe_accum_enable      <= (state_nxt == S_STREAM) || (state_nxt == S_FLUSH);
      stream_q             <= (state_nxt == S_STREAM);
      pad_q                <= (state_nxt == S_CLEAR) || (state_nxt == S_FLUSH);
      busy                 <= is_busy(state_nxt);
      if (job_fire) begin
        remaining         <= job_len;
        pe_precision_mode <= job_precision;
        pe_lane_mask      <= job_lane_mask;
      end else if (state == S_STREAM && op_fire) begin
        remaining <= remaining - LEN_W'(1);
      end
      if (state == S_CAPTURE) res_data <= pe_accum_out;
    end
  end

  // CLEAR/FLUSH drive a zero beat; STREAM passes the operand stream straight through.
  assign pe_data_valid = pad_q || (stream_q && op_valid);
  assign pe_data_a     = stream_q ? op_a : '0;
  assign pe_data_b     = stream_q ? op_b : '0;

endmodule
`default_nettype wire
